// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, ALUOp and select encodings shared by the multicycle control unit.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/op[5]/funct7_5 to the ALU control code.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7_5_i,
    output logic [2:0] alu_ctrl_o
);

    logic [2:0] funct_ctrl;

    // op[5] separates R-type from I-type so addi with Instr[30]=1 stays an add
    always_comb
        funct_ctrl = funct3_i == 3'b000 ? ((op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD) :
                     funct3_i == 3'b010 ? ALU_SLT :
                     funct3_i == 3'b110 ? ALU_OR  :
                     funct3_i == 3'b111 ? ALU_AND : ALU_ADD;

    always_comb
        alu_ctrl_o = alu_op_i == ALUOP_SUB   ? ALU_SUB :
                     alu_op_i == ALUOP_FUNCT ? funct_ctrl : ALU_ADD;

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RISC-V control unit (Moore FSM, one state per cycle).
// Define MC_CTRL_BNE_EN to add bne (funct3=001) to the branch opcode.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op
);

    state_t     state_q;
    state_t     decode_next;
    logic [1:0] alu_op;
    logic       branch_taken;

    always_comb begin
        decode_next = S_FETCH;
        case (op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_R:         decode_next = S_EXECR;
            OP_I:         decode_next = S_EXECI;
`ifdef MC_CTRL_BNE_EN
            OP_BEQ:       decode_next = funct3[2:1] == 2'b00 ? S_BEQ : S_FETCH;
`else
            OP_BEQ:       decode_next = S_BEQ;
`endif
            OP_JAL:       decode_next = S_JAL;
            default:      decode_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state_q <= S_FETCH;
        else
            case (state_q)
                S_FETCH:    state_q <= S_DECODE;
                S_DECODE:   state_q <= decode_next;
                S_MEMADR:   state_q <= op == OP_LW ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_EXECR:    state_q <= S_ALUWB;
                S_EXECI:    state_q <= S_ALUWB;
                S_JAL:      state_q <= S_ALUWB;
                default:    state_q <= S_FETCH;
            endcase

`ifdef MC_CTRL_BNE_EN
    assign branch_taken = zero ^ funct3[0];
`else
    assign branch_taken = zero;
`endif

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_4;
                result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_A;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_A;
                alu_op    = ALUOP_SUB;
                pc_write  = branch_taken;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_4;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_op = state_q == S_DECODE && decode_next == S_FETCH;

    assign imm_src = op == OP_SW  ? IMM_S :
                     op == OP_BEQ ? IMM_B :
                     op == OP_JAL ? IMM_J : IMM_I;

    alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .op5_i      (op[5]),
        .funct7_5_i (funct7_5),
        .alu_ctrl_o (alu_ctrl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random and directed instruction streams checked cycle by cycle against a per-instruction control table.
module tb_mc_control_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0, reset = 1'b0;
    logic [6:0] op = LW;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0, zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    int         errors = 0, checks = 0;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal_op};
    endfunction

    function automatic bit known(logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
    endfunction

    function automatic int latency(logic [6:0] o);
        return o == LW ? 5 : o == BQ ? 3 : known(o) ? 4 : 2;
    endfunction

    function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (o == RT && f7) ? 3'b110 : 3'b010;
            3'b010:  return 3'b111;
            3'b110:  return 3'b001;
            3'b111:  return 3'b000;
            default: return 3'b010;
        endcase
    endfunction

    // expected controls for cycle c (1-based) of an instruction with opcode o
    function automatic ctl_t model(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int c);
        ctl_t e = '0;
        e.imm = o == SW ? 2'b01 : o == BQ ? 2'b10 : o == JL ? 2'b11 : 2'b00;
        e.ac  = 3'b010;
        if (c == 1) begin
            e.pcw = 1; e.irw = 1; e.sb = 2'b10; e.rs = 2'b10;
        end else if (c == 2) begin
            e.sa = 2'b01; e.sb = 2'b01; e.ill = !known(o);
        end else if (o == LW || o == SW) begin
            if (c == 3) begin e.sa = 2'b10; e.sb = 2'b01; end
            else if (c == 4) begin e.adr = 1; e.mw = (o == SW); end
            else begin e.rs = 2'b01; e.rw = 1; end
        end else if (o == RT || o == IT) begin
            if (c == 3) begin e.sa = 2'b10; e.sb = (o == IT) ? 2'b01 : 2'b00; e.ac = funct_alu(o, f3, f7); end
            else e.rw = 1;
        end else if (o == BQ) begin
            e.sa = 2'b10; e.ac = 3'b110; e.pcw = z;
        end else if (o == JL) begin
            if (c == 3) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            else e.rw = 1;
        end
        return e;
    endfunction

    // zsel < 0 randomises zero each cycle; abort_c > 0 pulses reset during that cycle
    task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic f7, int zsel, int abort_c);
        ctl_t e, g;
        op = o; funct3 = f3; funct7_5 = f7;
        for (int c = 1; c <= latency(o); c++) begin
            zero = zsel < 0 ? 1'($urandom_range(0, 1)) : 1'(zsel);
            @(negedge clk);
            e = model(o, f3, f7, zero, c);
            g = observed();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, g, e);
            end
            if (c == abort_c) begin
                #2 reset = 1'b1;
                #1 g = observed();
                e = model(o, f3, f7, zero, 1);
                checks++;
                if (g !== e || reg_write !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async reset: got %b expected %b", name, g, e);
                end
                @(posedge clk); #1 reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        ctl_t g, e;
        #1 reset = 1'b1;
        #1 g = observed();
        e = model(op, funct3, funct7_5, zero, 1);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", g, e);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_directed();
        run_instr("lw",        LW, 3'b010, 1'b0, -1, 0);
        run_instr("sw",        SW, 3'b010, 1'b0, -1, 0);
        run_instr("sub",       RT, 3'b000, 1'b1, -1, 0);
        run_instr("add",       RT, 3'b000, 1'b0, -1, 0);
        run_instr("and",       RT, 3'b111, 1'b0, -1, 0);
        run_instr("slt",       RT, 3'b010, 1'b1, -1, 0);
        run_instr("or",        RT, 3'b110, 1'b0, -1, 0);
        run_instr("addi_f7",   IT, 3'b000, 1'b1, -1, 0);
        run_instr("i_f3_001",  IT, 3'b001, 1'b1, -1, 0);
        run_instr("beq_taken", BQ, 3'b000, 1'b0,  1, 0);
        run_instr("beq_not",   BQ, 3'b000, 1'b0,  0, 0);
        run_instr("jal",       JL, 3'b000, 1'b0, -1, 0);
        run_instr("illegal",   7'b1111111, 3'b000, 1'b0, -1, 0);
    endtask

    task automatic test_mid_reset();
        run_instr("mid_execr", RT, 3'b000, 1'b1, -1, 3);
        run_instr("after_rst", LW, 3'b000, 1'b0, -1, 0);
        run_instr("mid_memwb", LW, 3'b000, 1'b0, -1, 4);
        run_instr("after_rs2", RT, 3'b111, 1'b0, -1, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};
        logic [6:0] o;
        for (int n = 0; n < 80; n++) begin
            int k = $urandom_range(0, 6);
            if (k < 6) o = ops[k];
            else begin
                o = 7'($urandom);
                while (known(o)) o = 7'($urandom);
            end
            run_instr("random", o, 3'($urandom), 1'($urandom_range(0, 1)), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_reset();
        test_random();
        test_directed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit that produces every datapath control, including `alu_ctrl` for the ALU.
- Decodes `op`, `funct3` and `funct7_5` from the instruction register, steps a Moore FSM through one state per cycle, and samples the ALU `zero` flag for branches.
- Supports lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal.

Parameters:
- None. Encodings are fixed in the package.

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `op`  input  7  Instr[6:0]
- `funct3`  input  3  Instr[14:12]
- `funct7_5`  input  1  Instr[30]
- `zero`  input  1  ALU zero flag, same cycle
- `pc_write`  output  1  PC register enable
- `adr_src`  output  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  output  1  data memory write enable
- `ir_write`  output  1  instruction and OldPC register enable
- `reg_write`  output  1  register file write enable
- `result_src`  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `alu_src_a`  output  2  00 = PC, 01 = OldPC, 10 = A (RD1)
- `alu_src_b`  output  2  00 = B (RD2), 01 = ImmExt, 10 = constant 4
- `imm_src`  output  2  00 = I, 01 = S, 10 = B, 11 = J
- `alu_ctrl`  output  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt
- `illegal_op`  output  1  high in DECODE when `op` is unsupported

Behaviour:
- State register is asynchronously reset to FETCH. There are no other flops.
- All outputs except `imm_src` and `illegal_op` are a Moore function of state plus `funct3` and `funct7_5` for `alu_ctrl`. `pc_write` in BEQ additionally depends on `zero`.
- Every enable not listed for a state is 0. Every select not listed is 00.
- During reset, outputs equal the FETCH values. The datapath registers are held in reset concurrently, so this is harmless.
- State transitions and per-state outputs:
  - FETCH: `adr_src`=0, `ir_write`=1, `alu_src_a`=00, `alu_src_b`=10, ALUOp=add, `result_src`=10, `pc_write`=1. Next state DECODE.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, ALUOp=add (branch target). Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - other → FETCH, with `illegal_op`=1 for this cycle only
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. Next state MEMREAD if `op`=lw, else MEMWRITE.
  - MEMREAD: `result_src`=00, `adr_src`=1. Next state MEMWB.
  - MEMWB: `result_src`=01, `reg_write`=1. Next state FETCH.
  - MEMWRITE: `result_src`=00, `adr_src`=1, `mem_write`=1. Next state FETCH.
  - EXECR: `alu_src_a`=10, `alu_src_b`=00, ALUOp=funct. Next state ALUWB.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, ALUOp=funct. Next state ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. Next state FETCH.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00, `pc_write`=`zero`. Next state FETCH.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`=1. Next state ALUWB.
- Latencies in cycles: lw 5, sw 4, R-type/I-type 4, beq 3, jal 4, illegal 2.
- ALUOp=funct decode of `alu_ctrl`:
  - `funct3`=000: sub if (`op`[5] & `funct7_5`), else add. addi with Instr[30]=1 is therefore add.
  - `funct3`=010: slt.
  - `funct3`=110: or.
  - `funct3`=111: and.
  - Any other `funct3`: add.
- `imm_src` is combinational from `op`: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronous). The partial instruction is abandoned and no further write enables fire.
- Undefined state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro `MC_CTRL_BNE_EN`.
- Defined:
  - `op`=1100011 with `funct3`=001 is bne.
  - The BEQ state drives `pc_write`=~`zero`.
  - `funct3` values other than 000 and 001 raise `illegal_op` in DECODE and return to FETCH.
- Undefined:
  - BEQ state always drives `pc_write`=`zero`, regardless of `funct3`.

Decomposition:
- Package `mc_ctrl_pkg` holds:
  - state enum
  - opcode constants
  - ALUOp codes
  - `alu_ctrl` codes (010/110/000/001/111)
  - `result_src`, `alu_src_a`, `alu_src_b` and `imm_src` select codes
- Sub-module `alu_decoder`: combinational map of ALUOp, `funct3`, `op`[5] and `funct7_5` to `alu_ctrl`. It is instantiated once in the FSM.

Test Plan:
- Reset pulse mid-EXECR → state FETCH in the same cycle; `reg_write`=0 afterward. First post-reset cycle shows `ir_write`=1, `pc_write`=1, `alu_src_b`=10, `alu_ctrl`=010.
- `op`=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 only in cycle 5 with `result_src`=01. `imm_src`=00 throughout.
- `op`=0100011 → 4 cycles. `mem_write`=1 only in cycle 4 with `adr_src`=1. `imm_src`=01.
- `op`=0110011, `funct3`=000, `funct7_5`=1 → `alu_ctrl`=110 in EXECR. With `funct3`=111 → 000. With `funct3`=010 → 111. `op`=0010011 with `funct7_5`=1 → 010.
- `op`=1100011 with `zero`=1 → `pc_write`=1 in cycle 3. With `zero`=0 → `pc_write`=0. Next state FETCH both times.
- `op`=1101111 → JAL with `pc_write`=1, then ALUWB with `reg_write`=1. `op`=1111111 → `illegal_op`=1 in DECODE, then FETCH, with no write enables.
